// File: rtl/data_mem_resp_pkg.sv
// Shared constants for the data-memory responder: load/store funct3 codes,
// FSM state encoding and the access legality check.
package data_mem_resp_pkg;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic access_err(input logic is_wr, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic ill;
        logic mis;
        if (is_wr) begin
            ill = (f3 > INST_SW);
        end else begin
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        case (f3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return ill | mis;
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Load/store request bus between the execute stage (master) and the
// data-memory responder (slave).
interface data_mem_resp_if;
    // A request is any cycle with mem_r_ena_i or mem_w_ena_i high; the master holds
    // it stable while stall_o is high and the slave answers with a one-cycle
    // resp_valid_o strobe carrying rdata_o/err_o, during which stall_o is low.
    logic        mem_r_ena_i;
    logic        mem_w_ena_i;
    logic [31:0] mem_r_addr_i;
    logic [31:0] mem_w_addr_i;
    logic [31:0] mem_w_data_i;
    logic [2:0]  funct3_i;
    logic        stall_o;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output mem_r_ena_i, mem_w_ena_i, mem_r_addr_i, mem_w_addr_i, mem_w_data_i, funct3_i,
        input  stall_o, resp_valid_o, rdata_o, err_o
    );

    modport slave (
        input  mem_r_ena_i, mem_w_ena_i, mem_r_addr_i, mem_w_addr_i, mem_w_data_i, funct3_i,
        output stall_o, resp_valid_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_mem_resp_dmem_bank.sv
// Word-wide data array built from four byte-lane synchronous RAMs with
// per-lane write enables and a registered read port.
module dmem_bank #(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i[g]) begin
                mem[addr_i] <= wdata_i[8*g +: 8];
            end
            rd_q <= mem[addr_i];
        end

        assign rdata_o[8*g +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: serialises load/store requests, inserts wait states,
// steers byte lanes and returns extended load data with an error flag.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    data_mem_resp_if.slave       bus,
    output state_t               state_dbg_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req;
    logic [31:0]   req_addr;
    logic          stall;
    logic          do_access;
    logic [1:0]    lane;
    logic          acc_err;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [3:0]    bank_we;
    logic [AW-1:0] bank_addr;
    logic [31:0]   bank_rdata;
    logic [31:0]   ld_shift;
    logic [31:0]   ld_ext;
    logic          unused_addr_bits;

    assign req      = bus.mem_r_ena_i | bus.mem_w_ena_i;
    assign req_addr = bus.mem_w_ena_i ? bus.mem_w_addr_i : bus.mem_r_addr_i;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    is_wr_d = bus.mem_w_ena_i;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = bus.mem_w_data_i;
                    f3_d    = bus.funct3_i;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_BUSY;
                    stall   = 1'b1;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign do_access = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign lane      = addr_q[1:0];
    assign acc_err   = access_err(is_wr_q, f3_q, lane);

    always_comb begin
        st_be   = 4'b0000;
        st_data = ZERO_WORD;
        case (f3_q)
            INST_SB: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{wdata_q[7:0]}};
            end
            INST_SH: begin
                st_be   = 4'b0011 << lane;
                st_data = {2{wdata_q[15:0]}};
            end
            INST_SW: begin
                st_be   = 4'b1111;
                st_data = wdata_q;
            end
            default: ;
        endcase
    end

    assign bank_we = (do_access && is_wr_q && !acc_err) ? st_be : 4'b0000;
    // The read is launched at the accept edge so it is ready even with zero wait states.
    assign bank_addr = (state_q == ST_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk    (clk),
        .addr_i (bank_addr),
        .we_i   (bank_we),
        .wdata_i(st_data),
        .rdata_o(bank_rdata)
    );

    assign ld_shift = bank_rdata >> {lane, 3'b000};

    always_comb begin
        ld_ext = ZERO_WORD;
        case (f3_q)
            INST_LB:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            INST_LBU: ld_ext = {24'h0, ld_shift[7:0]};
            INST_LH:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            INST_LHU: ld_ext = {16'h0, ld_shift[15:0]};
            INST_LW:  ld_ext = ld_shift;
            default:  ld_ext = ZERO_WORD;
        endcase
    end

    assign resp_valid_d = do_access;
    assign err_d        = do_access && acc_err;
    assign rdata_d      = (do_access && !is_wr_q && !acc_err) ? ld_ext : ZERO_WORD;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            is_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= ZERO_WORD;
            f3_q         <= 3'b000;
            resp_valid_q <= 1'b0;
            rdata_q      <= ZERO_WORD;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            f3_q         <= f3_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.stall_o      = stall;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.err_o        = err_q;
    assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: two instances (0 and 3 wait states) driven with
// directed and random loads/stores, checked by a byte-addressed memory model.
module tb_data_mem_resp;
    import data_mem_resp_pkg::*;

    localparam int W0 = 0;
    localparam int W1 = 3;
    localparam int BYTES = 4 * 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst0_n, arst1_n;
    state_t st0, st1;

    data_mem_resp_if bus0 ();
    data_mem_resp_if bus1 ();

    data_mem_resp #(.DEPTH_WORDS(4096), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .arst_n(arst0_n), .bus(bus0), .state_dbg_o(st0)
    );
    data_mem_resp #(.DEPTH_WORDS(4096), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .arst_n(arst1_n), .bus(bus1), .state_dbg_o(st1)
    );

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [7:0]  mdl [2][BYTES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory is a flat byte array, results are built by arithmetic.
    function automatic logic [32:0] model_access(input int d, input logic wr,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] wdata,
                                                 input logic [2:0] f3);
        int size;
        longint val;
        int unsigned base;
        size = 0;
        if (wr) begin
            if (f3 == 3'd0) size = 1;
            else if (f3 == 3'd1) size = 2;
            else if (f3 == 3'd2) size = 4;
        end else begin
            if (f3 == 3'd0 || f3 == 3'd4) size = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
            else if (f3 == 3'd2) size = 4;
        end
        if (size == 0 || (addr % size) != 0) return {1'b1, 32'h0};
        base = addr % BYTES;
        if (wr) begin
            for (int i = 0; i < size; i++) mdl[d][base + i] = 8'((wdata >> (8 * i)) & 32'hFF);
            return {1'b0, 32'h0};
        end
        val = 0;
        for (int i = 0; i < size; i++) val = val + (longint'(mdl[d][base + i]) << (8 * i));
        if (size < 4 && f3[2] == 1'b0 && val >= (longint'(1) << (8 * size - 1)))
            val = val - (longint'(1) << (8 * size));
        return {1'b0, 32'(val)};
    endfunction

    task automatic drive(input int d, input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        if (d == 0) begin
            bus0.mem_w_ena_i = wr; bus0.mem_r_ena_i = rd;
            bus0.mem_w_addr_i = addr; bus0.mem_r_addr_i = addr;
            bus0.mem_w_data_i = wdata; bus0.funct3_i = f3;
        end else begin
            bus1.mem_w_ena_i = wr; bus1.mem_r_ena_i = rd;
            bus1.mem_w_addr_i = addr; bus1.mem_r_addr_i = addr;
            bus1.mem_w_data_i = wdata; bus1.funct3_i = f3;
        end
    endtask

    function automatic logic stall_of(input int d);
        return (d == 0) ? bus0.stall_o : bus1.stall_o;
    endfunction

    task automatic do_req(input int d, input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        int stalls;
        logic [32:0] e;
        e = model_access(d, wr, addr, wdata, f3);
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        @(negedge clk);
        drive(d, wr, rd, addr, wdata, f3);
        #1;
        stalls = 0;
        while (stall_of(d) && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check($sformatf("stall_cycles_dut%0d", d), stalls, (d == 0) ? W0 + 2 : W1 + 2);
        check($sformatf("resp_when_unstalled_dut%0d", d),
              (d == 0) ? bus0.resp_valid_o : bus1.resp_valid_o, 1);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        #1;
        check($sformatf("post_resp_clear_dut%0d", d),
              (d == 0) ? {bus0.resp_valid_o, bus0.err_o, bus0.rdata_o[29:0]}
                       : {bus1.resp_valid_o, bus1.err_o, bus1.rdata_o[29:0]}, 32'h0);
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (bus0.resp_valid_o) begin
            if (exp_q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_resp_dut0 actual=resp required=none");
            end else begin
                e = exp_q0.pop_front();
                check("rdata_dut0", bus0.rdata_o, e[31:0]);
                check("err_dut0", {31'h0, bus0.err_o}, {31'h0, e[32]});
            end
        end
        if (bus1.resp_valid_o) begin
            if (exp_q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_resp_dut1 actual=resp required=none");
            end else begin
                e = exp_q1.pop_front();
                check("rdata_dut1", bus1.rdata_o, e[31:0]);
                check("err_dut1", {31'h0, bus1.err_o}, {31'h0, e[32]});
            end
        end
    end

    task automatic random_phase(input int d, input int n);
        logic wr, rd;
        logic [31:0] addr;
        for (int k = 0; k < 8; k++) do_req(d, 1'b1, 1'b0, 32'h100 + 32'(4 * k), $urandom, 3'b010);
        for (int i = 0; i < n; i++) begin
            wr = ($urandom_range(0, 2) == 0);
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            addr = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr = addr + 32'h4000 * 32'($urandom_range(1, 5));
            do_req(d, wr, rd, addr, $urandom, 3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        arst0_n = 1'b0;
        arst1_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state_dut0", 32'(st0), 32'(ST_IDLE));
        check("reset_outputs_dut0", {bus0.resp_valid_o, bus0.err_o, bus0.stall_o, bus0.rdata_o[28:0]}, 0);
        check("reset_outputs_dut1", {bus1.resp_valid_o, bus1.err_o, bus1.stall_o, bus1.rdata_o[28:0]}, 0);
        arst0_n = 1'b1;
        arst1_n = 1'b1;

        // Directed: word, sub-word and lane accesses with zero wait states.
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, INST_SW);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, INST_LW);
        do_req(0, 1'b0, 1'b1, 32'h13, 32'h0, INST_LB);
        do_req(0, 1'b0, 1'b1, 32'h13, 32'h0, INST_LBU);
        do_req(0, 1'b0, 1'b1, 32'h12, 32'h0, INST_LH);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, INST_LHU);
        do_req(0, 1'b1, 1'b0, 32'h11, 32'h000000AA, INST_SB);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, INST_LW);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h01234567, INST_SW);
        do_req(0, 1'b1, 1'b0, 32'h14, 32'h89ABCDEF, INST_SW);
        do_req(0, 1'b0, 1'b1, 32'h22, 32'h0, INST_LW);
        do_req(0, 1'b1, 1'b0, 32'h15, 32'h0000FFFF, INST_SH);
        do_req(0, 1'b1, 1'b0, 32'h14, 32'h0000FFFF, 3'b011);
        do_req(0, 1'b0, 1'b1, 32'h14, 32'h0, INST_LW);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h0, 3'b110);
        do_req(0, 1'b1, 1'b1, 32'h40, 32'h12345678, INST_SW);
        do_req(0, 1'b0, 1'b1, 32'h40, 32'h0, INST_LW);
        do_req(0, 1'b0, 1'b1, 32'h4040, 32'h0, INST_LW);
        do_req(0, 1'b1, 1'b0, 32'h16, 32'h0000A5C3, INST_SH);
        do_req(0, 1'b0, 1'b1, 32'h16, 32'h0, INST_LH);
        random_phase(0, 60);

        // Wait states, then reset during the BUSY phase of a store.
        do_req(1, 1'b1, 1'b0, 32'h80, 32'h11112222, INST_SW);
        do_req(1, 1'b0, 1'b1, 32'h80, 32'h0, INST_LW);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h80, 32'hFFFFFFFF, INST_SW);
        @(negedge clk);
        #1;
        check("busy_before_reset", 32'(st1), 32'(ST_BUSY));
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        arst1_n = 1'b0;
        #1;
        check("state_after_reset", 32'(st1), 32'(ST_IDLE));
        check("outputs_after_reset", {bus1.resp_valid_o, bus1.err_o, bus1.stall_o, bus1.rdata_o[28:0]}, 0);
        repeat (2) @(negedge clk);
        arst1_n = 1'b1;
        do_req(1, 1'b0, 1'b1, 32'h80, 32'h0, INST_LW);
        random_phase(1, 40);

        repeat (4) @(negedge clk);
        check("queue0_drained", exp_q0.size(), 0);
        check("queue1_drained", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
